// File: rtl/gfx_framebuffer.sv
// ---------------------------------------------------------------------------
// gfx_framebuffer
//
// Single-clock pixel framebuffer. A renderer writes packed 4-bit pixels at
// (x, y); a free-running 1024x512 raster scanner reads the store back in
// display order and presents scan coordinates, pixel value and an active
// flag to the video output stage.
//
// Parameters:
//   WIDTH_IN  write data width (4, 8, 16 or 32); P = WIDTH_IN/4 pixels/word
//   WIDTH     visible pixels per line (<= 1024, multiple of P)
//   HEIGHT    visible lines (<= 512)
//
// Ports:
//   in_clk      sole clock, rising edge
//   in_reset    asynchronous active-high reset (synchronous release upstream)
//   in_enable   write strobe, one write accepted per cycle
//   in_x, in_y  write coordinates (low log2(P) bits of in_x ignored)
//   in_data     packed pixels, bits [3:0] = pixel at lowest x
//   out_x/out_y scan position of the presented pixel
//   out_pixel   pixel value at (out_x, out_y), 0 outside the visible area
//   out_active  high when out_x < WIDTH and out_y < HEIGHT
//
// Build option:
//   FRAMEBUFFER_BOUNDS_CHECK_EN  when defined, writes with in_x >= WIDTH or
//   in_y >= HEIGHT are dropped. When undefined, the write address is taken
//   modulo the word count, so out-of-range writes alias into storage.
//
// Storage is not cleared by reset; contents are undefined until written.
// ---------------------------------------------------------------------------
module gfx_framebuffer #(
  parameter int WIDTH_IN = 4,
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480
) (
  input  logic                in_clk,
  input  logic                in_reset,
  input  logic                in_enable,
  input  logic [9:0]          in_x,
  input  logic [8:0]          in_y,
  input  logic [WIDTH_IN-1:0] in_data,
  output logic [9:0]          out_x,
  output logic [8:0]          out_y,
  output logic [3:0]          out_pixel,
  output logic                out_active
);

  // -------------------------------------------------------------------------
  // Geometry
  // -------------------------------------------------------------------------
  localparam int P      = WIDTH_IN / 4;          // pixels per word
  localparam int LOG_P  = $clog2(P);             // 0 when P == 1
  localparam int WPL    = WIDTH / P;             // words per visible line
  localparam int WORDS  = WPL * HEIGHT;          // total storage words
  localparam int AW     = $clog2(WORDS);         // word address width
  localparam int CALC_W = 21;                    // wide enough for 511*1024+1023

  // -------------------------------------------------------------------------
  // Raster scanner
  // -------------------------------------------------------------------------
  logic [9:0] sx_reg;
  logic [8:0] sy_reg;
  logic       scan_visible;

  // 11/10-bit compares so WIDTH = 1024 and HEIGHT = 512 remain representable.
  assign scan_visible = ({1'b0, sx_reg} < 11'(WIDTH)) &&
                        ({1'b0, sy_reg} < 10'(HEIGHT));

  // -------------------------------------------------------------------------
  // Write address generation
  // -------------------------------------------------------------------------
  logic [CALC_W-1:0] wr_linear;
  logic [AW-1:0]     wr_addr;
  logic              wr_en;

  // Dropping the low log2(P) bits of in_x word-aligns every write.
  assign wr_linear = CALC_W'(in_y) * CALC_W'(WPL) + CALC_W'(in_x >> LOG_P);

`ifdef FRAMEBUFFER_BOUNDS_CHECK_EN
  logic wr_in_bounds;

  assign wr_in_bounds = ({1'b0, in_x} < 11'(WIDTH)) &&
                        ({1'b0, in_y} < 10'(HEIGHT));
  assign wr_en        = in_enable && wr_in_bounds;
  // In-bounds coordinates always give an address below WORDS.
  assign wr_addr      = AW'(wr_linear);
`else
  assign wr_en        = in_enable;
  // Out-of-range coordinates wrap around the store instead of being checked.
  assign wr_addr      = AW'(wr_linear % CALC_W'(WORDS));
`endif

  // -------------------------------------------------------------------------
  // Read address generation
  // -------------------------------------------------------------------------
  logic [AW-1:0] rd_addr;

  // Blanking positions would overflow the store; park the read on word 0,
  // the result is masked off by the registered active flag anyway.
  assign rd_addr = scan_visible
                 ? AW'(CALC_W'(sy_reg) * CALC_W'(WPL) + CALC_W'(sx_reg >> LOG_P))
                 : '0;

  // -------------------------------------------------------------------------
  // Pixel store: simple dual-port RAM with registered read.
  // Both accesses use non-blocking assignment in the same block, so a read
  // and write to the same word in one cycle returns the old contents.
  // -------------------------------------------------------------------------
  logic [WIDTH_IN-1:0] mem [WORDS];
  logic [WIDTH_IN-1:0] rd_word_reg;

  always_ff @(posedge in_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in_data;
    end
    rd_word_reg <= mem[rd_addr];
  end

  // -------------------------------------------------------------------------
  // Scan counters and presentation registers
  // -------------------------------------------------------------------------
  logic [9:0] out_x_reg;
  logic [8:0] out_y_reg;
  logic       active_reg;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      sx_reg     <= '0;
      sy_reg     <= '0;
      out_x_reg  <= '0;
      out_y_reg  <= '0;
      active_reg <= 1'b0;
    end else begin
      // sx wraps 1023 -> 0 naturally; sy steps on that wrap and wraps 511 -> 0.
      sx_reg <= sx_reg + 10'd1;
      if (&sx_reg) begin
        sy_reg <= sy_reg + 9'd1;
      end
      // Coordinates are delayed by one cycle to line up with the RAM read.
      out_x_reg  <= sx_reg;
      out_y_reg  <= sy_reg;
      active_reg <= scan_visible;
    end
  end

  // -------------------------------------------------------------------------
  // Pixel lane select
  // -------------------------------------------------------------------------
  logic [3:0] lane [P];
  logic [3:0] pixel_sel;

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    assign lane[gi] = rd_word_reg[4*gi +: 4];
  end

  if (P > 1) begin : g_multi
    logic [LOG_P-1:0] sel_reg;

    // Lane index travels alongside the read so it matches the fetched word.
    always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
        sel_reg <= '0;
      end else begin
        sel_reg <= sx_reg[LOG_P-1:0];
      end
    end

    assign pixel_sel = lane[sel_reg];
  end else begin : g_single
    assign pixel_sel = lane[0];
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // active_reg is cleared by reset, which also forces out_pixel to 0 while
  // the (unreset) RAM output register still holds stale data.
  assign out_x      = out_x_reg;
  assign out_y      = out_y_reg;
  assign out_active = active_reg;
  assign out_pixel  = active_reg ? pixel_sel : 4'h0;

endmodule

// File: tb/tb_gfx_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_gfx_framebuffer
//
// Drives gfx_framebuffer (16-bit writes, 64x20 visible area) with random and
// directed writes and compares every presented raster position against a
// pixel-array reference model addressed by (x, y).
// ---------------------------------------------------------------------------
module tb_gfx_framebuffer;

  localparam int P     = 4;
  localparam int W     = 64;
  localparam int H     = 20;
  localparam int WPL   = W / P;
  localparam int WORDS = WPL * H;
  localparam int LINE  = 1024;
  localparam int ROWS  = 512;

  logic        clk = 1'b0;
  logic        in_reset;
  logic        in_enable;
  logic [9:0]  in_x;
  logic [8:0]  in_y;
  logic [15:0] in_data;
  logic [9:0]  out_x;
  logic [8:0]  out_y;
  logic [3:0]  out_pixel;
  logic        out_active;

  always #5 clk = ~clk;

  gfx_framebuffer #(
    .WIDTH_IN(16),
    .WIDTH   (W),
    .HEIGHT  (H)
  ) dut (
    .in_clk    (clk),
    .in_reset  (in_reset),
    .in_enable (in_enable),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_data   (in_data),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_pixel (out_pixel),
    .out_active(out_active)
  );

  // Reference model: one entry per visible pixel, indexed y*W + x.
  logic [3:0] fb    [W*H];
  bit         known [W*H];
  int         pos;          // raster positions presented since reset release
  int         checks;
  int         errors;

  task automatic model_write(input int x, input int y, input logic [15:0] d);
    int word;
`ifdef FRAMEBUFFER_BOUNDS_CHECK_EN
    if (x >= W || y >= H) return;
`endif
    word = (y * WPL + x / P) % WORDS;
    for (int k = 0; k < P; k++) begin
      fb[word*P + k]    = d[4*k +: 4];
      known[word*P + k] = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({out_x, out_y, out_pixel, out_active} === 24'h0)
    else begin
      errors++;
      $error("FAIL %s got x=%0d y=%0d px=%h act=%b exp all zero",
             tag, out_x, out_y, out_pixel, out_active);
    end
  endtask

  task automatic check_px(input string tag, input logic [3:0] exp_px);
    checks++;
    assert (out_pixel === exp_px)
    else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, out_pixel, exp_px);
    end
  endtask

  // Called just after a rising edge: apply inputs, clock once, compare.
  task automatic run_cycle(input logic en, input int x, input int y,
                           input logic [15:0] d);
    int         ex, ey;
    logic       eact;
    logic [3:0] epix;
    bit         eknown;
    in_enable = en;
    in_x      = 10'(x);
    in_y      = 9'(y);
    in_data   = d;
    ex     = pos % LINE;
    ey     = (pos / LINE) % ROWS;
    eact   = (ex < W) && (ey < H);
    epix   = eact ? fb[ey*W + ex] : 4'h0;
    eknown = eact ? known[ey*W + ex] : 1'b1;
    @(posedge clk);
    if (en) model_write(x, y, d);
    pos++;
    #1;
    checks++;
    assert ({out_x, out_y, out_active} === {10'(ex), 9'(ey), eact})
    else begin
      errors++;
      $error("FAIL scan_pos@%0d got x=%0d y=%0d act=%b exp x=%0d y=%0d act=%b",
             pos - 1, out_x, out_y, out_active, ex, ey, eact);
    end
    if (eknown) begin
      checks++;
      assert (out_pixel === epix)
      else begin
        errors++;
        $error("FAIL pixel(%0d,%0d) got %h exp %h", ex, ey, out_pixel, epix);
      end
    end
    in_enable = 1'b0;
  endtask

  // wild: also produce coordinates anywhere in the 10/9-bit range.
  task automatic rand_cycle(input bit wild);
    int x, y;
    if (wild && $urandom_range(0, 3) == 0) begin
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 511);
    end else begin
      x = $urandom_range(0, W - 1);
      y = wild ? $urandom_range(0, H - 1) : $urandom_range(4, H - 1);
    end
    run_cycle(1'($urandom_range(0, 1)), x, y, 16'($urandom));
  endtask

  // Fixed expectations for the directed writes, checked when presented.
  task automatic const_checks(input bit rescan);
    int p;
    p = pos - 1;
    case (p)
      2*LINE + 8:  check_px("packed_x8", 4'h1);
      2*LINE + 9:  check_px("packed_x9", 4'h2);
      2*LINE + 10: check_px("packed_x10", 4'h3);
      2*LINE + 11: check_px("packed_x11", 4'h4);
`ifndef FRAMEBUFFER_BOUNDS_CHECK_EN
      60:          check_px("alias_x60", 4'hF);
      61:          check_px("alias_x61", 4'h0);
`endif
      default: ;
    endcase
    if (rescan && p == LINE + 20) check_px("collide_new_x20", 4'hF);
    if (rescan && p == LINE + 23) check_px("collide_new_x23", 4'hB);
  endtask

  task automatic do_reset(input string tag);
    #2;
    in_reset  = 1'b1;
    in_enable = 1'b0;
    #1;
    check_zero({tag, "_async"});
    repeat (2) @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    in_reset = 1'b0;
    pos      = 0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pos       = 0;
    in_reset  = 1'b1;
    in_enable = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_data   = '0;
    for (int i = 0; i < W*H; i++) begin
      fb[i]    = 4'h0;
      known[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_initial");
    in_reset = 1'b0;
    pos      = 0;

    // Fill every word once so the whole visible store is defined.
    for (int w = 0; w < WORDS; w++) begin
      run_cycle(1'b1, (w % WPL) * P, w / WPL, 16'($urandom));
    end
    repeat (200) rand_cycle(1'b1);

    // Mid-scan reset: outputs drop at once, scan restarts at (0,0).
    do_reset("reset_midscan");

    for (int n = 0; n < (H + 1) * LINE; n++) begin
      if (n == 10)               run_cycle(1'b1, 700, 10, 16'h000F);
      else if (n == 50)          run_cycle(1'b1, 9, 2, 16'h4321);
      else if (n == LINE + 20)   run_cycle(1'b1, 20, 1, 16'hBEEF);
      else                       rand_cycle(1'b0);
      const_checks(1'b0);
    end

    // Restart the raster to observe the word written during the collision.
    do_reset("reset_rescan");
    for (int n = 0; n < 2*LINE + 64; n++) begin
      run_cycle(1'b0, 0, 0, 16'h0);
      const_checks(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gfx_framebuffer.md
# gfx_framebuffer

Single-clock pixel framebuffer for the gfx pipeline. A renderer writes packed 4-bit pixels at (x, y) coordinates. A free-running raster scanner reads the store back in display order and presents coordinates, pixel and active flag to the video output stage. The input word width is parameterisable so the same block serves 1-pixel and multi-pixel writers.

## Interface
Parameters:
- WIDTH_IN, 4, write data width in bits; multiple of 4; pixels per write P = WIDTH_IN/4 (legal: 4, 8, 16, 32).
- WIDTH, 640, visible pixels per line (≤1024, multiple of P).
- HEIGHT, 480, visible lines (≤512).

Ports (clock and reset first):
- in_clk  input  1  sole clock; all logic on rising edge.
- in_reset  input  1  reset, asynchronous and active-high.
- in_enable  input  1  write strobe.
- in_x  input  10  write x coordinate.
- in_y  input  9  write y coordinate.
- in_data  input  WIDTH_IN  packed pixels; bits [3:0] = pixel at lowest x.
- out_x  output  10  scan x of presented pixel.
- out_y  output  9  scan y of presented pixel.
- out_pixel  output  4  pixel value at (out_x, out_y).
- out_active  output  1  high when out_x < WIDTH and out_y < HEIGHT.

## Operation
- Storage: WIDTH*HEIGHT 4-bit pixels, organised as (WIDTH/P)*HEIGHT words of WIDTH_IN bits; word address = in_y*(WIDTH/P) + in_x/P.
- Write: on a clock edge with in_enable=1, store in_data at word for (in_x, in_y).
  - Low log2(P) bits of in_x are ignored; writes are always word-aligned.
  - Pixel k of the word (bits [4k+3:4k]) lands at x = aligned_x + k.
- Scan: internal counters sx (10 bit), sy (9 bit) advance every cycle.
  - sx 0→1023 then wraps to 0 and increments sy.
  - sy 0→511 then wraps to 0.
  - This gives a 1024x512 raster of 524288 cycles per frame.
- Readout: for the scan position, fetch the word, select pixel sx mod P, present it.
  - Outside the visible area, out_pixel = 0 and out_active = 0.
- Read/write collision on the same word in the same cycle: the read returns the old data (read-before-write).
- Storage contents are not cleared by reset; they are undefined until written.

## Timing
- Reset (asynchronous assert, synchronous release): sx = sy = 0; out_x = 0, out_y = 0, out_pixel = 0, out_active = 0.
- Read latency is 1 cycle. out_x, out_y, out_pixel and out_active are registered together and always mutually aligned.
- The first cycle after reset release presents (0,0). Each subsequent cycle presents the next raster position.
- Write-to-read: a pixel written at edge N is visible on out_pixel if its position is presented at edge N+1 or later.
- Reset asserted mid-frame: the scan restarts at (0,0) after release. A write on the same edge as reset assertion is not guaranteed.
- in_enable has no handshake. One write is accepted per cycle, unconditionally.

## Configuration
- FRAMEBUFFER_BOUNDS_CHECK_EN defined: writes with in_x ≥ WIDTH or in_y ≥ HEIGHT are discarded and leave storage unchanged.
- FRAMEBUFFER_BOUNDS_CHECK_EN undefined: no coordinate check. The computed address is taken modulo the word count, so out-of-range writes alias into storage. This saves a comparator pair.
- Readout behaviour is identical in both builds.

## Test plan
- Reset: assert in_reset mid-scan → all outputs 0 immediately; after release, out_x/out_y step (0,0),(1,0),(2,0)… one per cycle.
- Raster wrap: run 1024 cycles from reset → out_x wraps 1023→0 with out_y 0→1. After 524288 cycles, out_y wraps 511→0. out_active is 0 for x ≥ 640 or y ≥ 480.
- Single write, WIDTH_IN=4: write 4'hA at (5,3) → out_pixel = 4'hA when out_x=5, out_y=3; neighbours (4,3) and (6,3) keep prior written values.
- Packed write, WIDTH_IN=16: write 16'h4321 at in_x=9 (aligned to 8), y=2 → pixels (8..11, 2) read 1, 2, 3, 4.
- Bounds, FRAMEBUFFER_BOUNDS_CHECK_EN defined: write 4'hF at (700,10) → no visible pixel changes. Undefined: the same write aliases to address 10*(WIDTH/P)+700/P, and that pixel reads 4'hF.
- Collision: write the word at the current scan address → the old value is presented that frame and the new value on the next frame.
